// File: rtl/meter_pkg.sv
// rtl/meter_pkg.sv - shared widths, defaults and FSM state type for the meter sampler
package meter_pkg;

  localparam int ADC_W = 12;

  localparam int DEF_SAMPLE_DIV   = 2267;
  localparam int DEF_TIMEOUT      = 64;
  localparam int DEF_HOLD_SAMPLES = 4096;
  localparam int DEF_DECAY_STEP   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/peak_hold.sv
// rtl/peak_hold.sv - peak-hold with linear decay applied once per captured sample
module peak_hold
  import meter_pkg::*;
#(
  parameter int HOLD_SAMPLES = DEF_HOLD_SAMPLES,
  parameter int DECAY_STEP   = DEF_DECAY_STEP,
  localparam int HW          = $clog2(HOLD_SAMPLES) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADC_W-1:0] s,
  input  logic             sample_en,
  input  logic             src_change,
  output logic [ADC_W-1:0] level,
  output logic [HW-1:0]    hold
);

  localparam logic [ADC_W-1:0] STEP      = ADC_W'(DECAY_STEP);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_SAMPLES - 1);

  logic [ADC_W-1:0] base_l;
  logic [ADC_W-1:0] decayed;
  logic [ADC_W-1:0] next_l;
  logic [HW-1:0]    base_h;
  logic [HW-1:0]    next_h;

  // New level/hold: a source change restarts from zero, then new peak, hold, or decay
  always_comb begin
    base_l  = src_change ? '0 : level;
    base_h  = src_change ? '0 : hold;
    decayed = (base_l > STEP) ? (base_l - STEP) : '0;
    next_l  = base_l;
    next_h  = base_h;
    if (s >= base_l) begin
      next_l = s;
      next_h = '0;
    end else if (base_h < HOLD_LAST) begin
      next_h = base_h + HW'(1);
    end else begin
      next_l = (decayed > s) ? decayed : s;
    end
  end

  // Commit the update only when a conversion result is being captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
      hold  <= '0;
    end else if (sample_en) begin
      level <= next_l;
      hold  <= next_h;
    end
  end

endmodule

// File: rtl/meter_sample_ctrl.sv
// rtl/meter_sample_ctrl.sv - periodic ADC conversion scheduler feeding a peak-held meter level
module meter_sample_ctrl
  import meter_pkg::*;
#(
  parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int HOLD_SAMPLES = DEF_HOLD_SAMPLES,
  parameter int DECAY_STEP   = DEF_DECAY_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             switch,
  output logic             adc_start,
  output logic             adc_sel,
  input  logic             adc_done,
  input  logic [ADC_W-1:0] adc_data,
  output logic [ADC_W-1:0] level,
  output logic             level_valid,
  output logic             busy,
  output logic             timeout_err,
  output logic             overrun,
  input  logic             clr_err
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [WW-1:0]    wait_cnt;
  logic             wait_last;
  logic             timeout_evt;
  logic             sw_meta;
  logic             sw_sync;
  logic [ADC_W-1:0] sample;
  logic             src_pend;

  assign tick        = (tick_cnt == TW'(SAMPLE_DIV - 1));
  assign wait_last   = (wait_cnt == WW'(TIMEOUT - 1));
  assign timeout_evt = (state == ST_WAIT) && !adc_done && wait_last;
  assign adc_start   = (state == ST_START);
  assign busy        = (state != ST_IDLE);

  // Free-running conversion tick divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Two-stage synchronizer for the asynchronous source-select switch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta <= 1'b0;
      sw_sync <= 1'b0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

  // Conversion sequencer; adc_sel is latched on entry to START so it is valid for the whole conversion.
  // A source change stays pending until a conversion is actually captured, so an aborted
  // conversion on the new source does not lose the level reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      adc_sel  <= 1'b0;
      sample   <= '0;
      src_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state    <= ST_START;
            adc_sel  <= sw_sync;
            src_pend <= src_pend | (sw_sync != adc_sel);
          end
        end
        ST_START: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (adc_done) begin
            sample <= adc_data;
            state  <= ST_CAPTURE;
          end else if (wait_last) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        ST_CAPTURE: begin
          src_pend <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobe and sticky error flags; a new error wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_valid <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      level_valid <= (state == ST_CAPTURE);
      if (timeout_evt) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
      if (tick && busy) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

  peak_hold #(
    .HOLD_SAMPLES (HOLD_SAMPLES),
    .DECAY_STEP   (DECAY_STEP)
  ) u_peak_hold (
    .clk        (clk),
    .rst        (rst),
    .s          (sample),
    .sample_en  (state == ST_CAPTURE),
    .src_change (src_pend),
    .level      (level),
    .hold       ()
  );

endmodule

// File: tb/tb_meter_sample_ctrl.sv
// tb/tb_meter_sample_ctrl.sv - self-checking bench for meter_sample_ctrl with a behavioural level model
module tb_meter_sample_ctrl;

  localparam int SDIV  = 20;
  localparam int TOUT  = 8;
  localparam int HOLD  = 2;
  localparam int DSTEP = 100;

  logic        clk = 1'b0;
  logic        rst, switch, adc_done, clr_err;
  logic [11:0] adc_data;
  logic        adc_start, adc_sel, level_valid, busy, timeout_err, overrun;
  logic [11:0] level;

  logic        rst2, adc_done2;
  logic        adc_start2, adc_sel2, level_valid2, busy2, timeout_err2, overrun2;
  logic [11:0] level2;

  int errors = 0;
  int checks = 0;
  int m_level, m_hold, m_prev, m_terr;

  always #5 clk = ~clk;

  meter_sample_ctrl #(
    .SAMPLE_DIV(SDIV), .TIMEOUT(TOUT), .HOLD_SAMPLES(HOLD), .DECAY_STEP(DSTEP)
  ) dut (
    .clk(clk), .rst(rst), .switch(switch), .adc_start(adc_start), .adc_sel(adc_sel),
    .adc_done(adc_done), .adc_data(adc_data), .level(level), .level_valid(level_valid),
    .busy(busy), .timeout_err(timeout_err), .overrun(overrun), .clr_err(clr_err)
  );

  meter_sample_ctrl #(
    .SAMPLE_DIV(SDIV), .TIMEOUT(30), .HOLD_SAMPLES(HOLD), .DECAY_STEP(DSTEP)
  ) dut2 (
    .clk(clk), .rst(rst2), .switch(switch), .adc_start(adc_start2), .adc_sel(adc_sel2),
    .adc_done(adc_done2), .adc_data(adc_data), .level(level2), .level_valid(level_valid2),
    .busy(busy2), .timeout_err(timeout_err2), .overrun(overrun2), .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: restart on source change, then new peak / hold count / decay floored at the sample
  task automatic model_sample(input int sel, input int s);
    int d;
    if (sel != m_prev) begin
      m_level = 0;
      m_hold  = 0;
    end
    m_prev = sel;
    if (s >= m_level) begin
      m_level = s;
      m_hold  = 0;
    end else if (m_hold < HOLD - 1) begin
      m_hold = m_hold + 1;
    end else begin
      d = m_level - DSTEP;
      if (d < 0) d = 0;
      m_level = (d > s) ? d : s;
    end
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (adc_start !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", 32'(adc_start), 1);
  endtask

  task automatic do_conv(input int s, input int dly);
    int   n;
    logic sel;
    sel = switch;
    wait_start(n);
    chk("adc_sel", 32'(adc_sel), 32'(sel));
    repeat (dly) @(negedge clk);
    chk("busy_wait", 32'(busy), 1);
    adc_data = 12'(s);
    adc_done = 1'b1;
    @(negedge clk);
    adc_done = 1'b0;
    chk("valid_capture", 32'(level_valid), 0);
    model_sample(32'(sel), s);
    @(negedge clk);
    chk("valid_strobe", 32'(level_valid), 1);
    chk("level", 32'(level), m_level);
    chk("timeout_err", 32'(timeout_err), m_terr);
    @(negedge clk);
    chk("valid_after", 32'(level_valid), 0);
    chk("busy_after", 32'(busy), 0);
  endtask

  task automatic do_timeout();
    int n;
    wait_start(n);
    repeat (TOUT) @(negedge clk);
    chk("busy_last_wait", 32'(busy), 1);
    chk("terr_before", 32'(timeout_err), m_terr);
    @(negedge clk);
    m_terr = 1;
    chk("terr_set", 32'(timeout_err), 1);
    chk("busy_abort", 32'(busy), 0);
    chk("level_kept", 32'(level), m_level);
    repeat (3) begin
      chk("no_strobe", 32'(level_valid), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; rst2 = 1'b1; switch = 1'b1; adc_done = 1'b0; adc_done2 = 1'b0;
    clr_err = 1'b0; adc_data = '0;
    m_level = 0; m_hold = 0; m_prev = 0; m_terr = 0;
    repeat (3) @(negedge clk);
    chk("rst_adc_start", 32'(adc_start), 0);
    chk("rst_adc_sel", 32'(adc_sel), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(level_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_overrun", 32'(overrun), 0);

    rst = 1'b0;
    wait_start(n);
    chk("first_tick", n, SDIV);
    do_conv(1000, 3);
    chk("basic_level", 32'(level), 1000);
    do_conv(200, 2);
    do_conv(200, 5);
    do_conv(200, 1);
    chk("decayed_level", 32'(level), 800);
    do_conv(950, 4);

    do_timeout();
    do_conv(100, 2);
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    m_terr = 0;
    chk("terr_cleared", 32'(timeout_err), 0);

    do_conv(1000, 3);
    switch = 1'b0;
    do_conv(300, 4);
    chk("src_switch_level", 32'(level), 300);
    switch = 1'b1;
    do_conv(50, 2);
    do_conv(0, 2);
    do_conv(0, 2);
    chk("decay_floor", 32'(level), 0);
    do_conv(256, TOUT);
    chk("collision_level", 32'(level), 256);
    chk("collision_terr", 32'(timeout_err), 0);

    @(negedge clk); adc_data = 12'hFFF; adc_done = 1'b1;
    @(negedge clk); adc_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_done_valid", 32'(level_valid), 0);
      chk("idle_done_busy", 32'(busy), 0);
    end
    chk("idle_done_level", 32'(level), m_level);

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 4) == 0) switch = ~switch;
      do_conv($urandom_range(0, 1500), $urandom_range(1, TOUT));
    end

    @(negedge clk); rst2 = 1'b0;
    n = 0;
    while (adc_start2 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("dut2_first_tick", n, SDIV);
    repeat (SDIV - 1) @(negedge clk);
    chk("ovr_before", 32'(overrun2), 0);
    chk("ovr_busy", 32'(busy2), 1);
    @(negedge clk);
    chk("ovr_set", 32'(overrun2), 1);
    repeat (2) @(negedge clk);
    #1 rst2 = 1'b1;
    #1;
    chk("mid_rst_start", 32'(adc_start2), 0);
    chk("mid_rst_sel", 32'(adc_sel2), 0);
    chk("mid_rst_level", 32'(level2), 0);
    chk("mid_rst_valid", 32'(level_valid2), 0);
    chk("mid_rst_busy", 32'(busy2), 0);
    chk("mid_rst_terr", 32'(timeout_err2), 0);
    chk("mid_rst_ovr", 32'(overrun2), 0);
    @(negedge clk); rst2 = 1'b0;
    n = 0;
    while (adc_start2 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("dut2_restart_tick", n, SDIV);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
